key_conditioner: RTL and testbench

//   Front-end for the board push-buttons. Synchronises the raw active-low KEY

---
 rtl/key_conditioner.sv | 170 +++++++++++++++++
 tb/tb_key_conditioner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces the active-low board KEY pins
// and turns each one into a clean level, press/release pulses and an
// optional hold-to-repeat pulse train.
//
// Ports:
//   CLOCK_50    in   sole clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   KEY         in   raw buttons, asynchronous, 0 = pressed
//   key_level   out  debounced state, 1 = pressed
//   key_press   out  1-cycle pulse when key_level rises
//   key_release out  1-cycle pulse when key_level falls
//   key_repeat  out  1-cycle auto-repeat pulse while held
//   any_press   out  OR of key_press, same cycle
module key_conditioner #(
   parameter int NUM_KEYS        = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 25_000_000,
   parameter int REPEAT_CYCLES   = 5_000_000,
   parameter int REPEAT_EN       = 1
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_repeat,
   output logic                any_press
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                         HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] H_LAST = RW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } hold_state_e;

   // Synchroniser resets to the released level (KEY = 1).
   logic [NUM_KEYS-1:0] meta_q;
   logic [NUM_KEYS-1:0] sync_q;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= KEY;
         sync_q <= meta_q;
      end
   end

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic          s;
      logic [DW-1:0] dcnt_q, dcnt_d;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;

      assign s = ~sync_q[k];

      // Any sample agreeing with the current level clears the run;
      // DEBOUNCE_CYCLES disagreeing samples in a row flip the level.
      always_comb begin
         dcnt_d  = '0;
         level_d = level_q;
         if (s != level_q) begin
            if (dcnt_q == D_LAST) begin
               level_d = s;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         press_d = level_d & ~level_q;
         rel_d   = ~level_d & level_q;
      end

      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
         if (!RESET_N) begin
            dcnt_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
         end
      end

      assign key_level[k]   = level_q;
      assign key_press[k]   = press_q;
      assign key_release[k] = rel_q;

      if (REPEAT_EN != 0) begin : g_rep
         hold_state_e   state_q, state_d;
         logic [RW-1:0] rcnt_q, rcnt_d;
         logic          rep_q, rep_d;

         // The FSM follows the same edge that registers the press pulse,
         // so rcnt is 0 in the press cycle and the first repeat lands
         // HOLD_CYCLES later. A falling level wins over a due repeat.
         always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            rep_d   = 1'b0;
            unique case (state_q)
               IDLE: begin
                  rcnt_d = '0;
                  if (press_d) state_d = HOLD;
               end
               HOLD: begin
                  if (rel_d) begin
                     state_d = IDLE;
                     rcnt_d  = '0;
                  end else if (rcnt_q == H_LAST) begin
                     rep_d   = 1'b1;
                     state_d = REPEAT;
                     rcnt_d  = '0;
                  end else begin
                     rcnt_d = rcnt_q + RW'(1);
                  end
               end
               REPEAT: begin
                  if (rel_d) begin
                     state_d = IDLE;
                     rcnt_d  = '0;
                  end else if (rcnt_q == R_LAST) begin
                     rep_d  = 1'b1;
                     rcnt_d = '0;
                  end else begin
                     rcnt_d = rcnt_q + RW'(1);
                  end
               end
               default: begin
                  state_d = IDLE;
                  rcnt_d  = '0;
               end
            endcase
         end

         always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
               state_q <= IDLE;
               rcnt_q  <= '0;
               rep_q   <= 1'b0;
            end else begin
               state_q <= state_d;
               rcnt_q  <= rcnt_d;
               rep_q   <= rep_d;
            end
         end

         assign key_repeat[k] = rep_q;
      end else begin : g_norep
         assign key_repeat[k] = 1'b0;
      end
   end

   assign any_press = |key_press;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random stimulus for key_conditioner,
// checked every cycle against a window/arithmetic reference model.
module tb_key_conditioner;

   localparam int NK   = 2;
   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int REP  = 5;

   logic          CLOCK_50 = 1'b0;
   logic          RESET_N  = 1'b1;
   logic [NK-1:0] KEY      = '1;
   logic [NK-1:0] key_level, key_press, key_release, key_repeat;
   logic          any_press;

   int checks   = 0;
   int failures = 0;
   int tb_cyc   = 0;

   key_conditioner #(
      .NUM_KEYS       (NK),
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD),
      .REPEAT_CYCLES  (REP),
      .REPEAT_EN      (1)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET_N    (RESET_N),
      .KEY        (KEY),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_repeat (key_repeat),
      .any_press  (any_press)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Reference model: level flips when the last DEB synchronised samples
   // all disagree with it; repeats fall at press + HOLD + n*REP.
   logic [NK-1:0] m_level = '0;
   logic [NK-1:0] m_press = '0;
   logic [NK-1:0] m_rel   = '0;
   logic [NK-1:0] m_rep   = '0;
   logic [NK-1:0] m_m1    = '1;
   logic [NK-1:0] m_m2    = '1;
   int            m_cyc   = 0;
   int            m_pc [NK];
   bit            m_hist [NK][$];

   always @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         m_level = '0;
         m_press = '0;
         m_rel   = '0;
         m_rep   = '0;
         m_m1    = '1;
         m_m2    = '1;
         m_cyc   = 0;
         for (int k = 0; k < NK; k++) m_hist[k].delete();
      end else begin
         m_cyc++;
         for (int k = 0; k < NK; k++) begin
            bit sv, nl, all;
            int d;
            sv = ~m_m2[k];
            m_hist[k].push_back(sv);
            if (m_hist[k].size() > DEB) void'(m_hist[k].pop_front());
            nl = m_level[k];
            if (m_hist[k].size() == DEB) begin
               all = 1'b1;
               for (int i = 0; i < DEB; i++)
                  if (m_hist[k][i] == m_level[k]) all = 1'b0;
               if (all) nl = ~m_level[k];
            end
            m_press[k] = nl & ~m_level[k];
            m_rel[k]   = ~nl & m_level[k];
            if (m_press[k]) m_pc[k] = m_cyc;
            d = m_cyc - m_pc[k];
            m_rep[k] = nl & m_level[k] & (d >= HOLD) &&
                       ((d - HOLD) % REP == 0);
            m_level[k] = nl;
            m_m2[k] = m_m1[k];
            m_m1[k] = KEY[k];
         end
      end
   end

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, tb_cyc, got, exp);
      end
   endtask

   task automatic cmp_all();
      chk("level",   32'(key_level),   32'(m_level));
      chk("press",   32'(key_press),   32'(m_press));
      chk("release", 32'(key_release), 32'(m_rel));
      chk("repeat",  32'(key_repeat),  32'(m_rep));
      chk("any",     32'(any_press),   32'(|m_press));
   endtask

   task automatic cyc();
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      tb_cyc++;
      cmp_all();
   endtask

   // Wait (bounded) for a press (rel=0) or release (rel=1) pulse on key k.
   task automatic wait_evt(int k, bit rel, output int lat);
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if ((rel ? key_release[k] : key_press[k]) === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_lvl"}, 32'(key_level),   0);
      chk({tag, "_prs"}, 32'(key_press),   0);
      chk({tag, "_rel"}, 32'(key_release), 0);
      chk({tag, "_rep"}, 32'(key_repeat),  0);
      chk({tag, "_any"}, 32'(any_press),   0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, p, nrep, bad, nev, np;
      #2 RESET_N = 1'b0;
      #1 chk_zero("rst");
      cyc();
      cyc();
      RESET_N = 1'b1;
      repeat (3) cyc();

      // 1 clean press and release
      KEY[0] = 1'b0;
      wait_evt(0, 1'b0, lat);
      chk("press_lat", 32'(lat >= 6 && lat <= 7), 1);
      chk("press_any", 32'(any_press), 1);
      chk("press_lvl", 32'(key_level[0]), 1);
      cyc();
      chk("press_width", 32'(key_press[0]), 0);
      repeat (4) cyc();
      KEY[0] = 1'b1;
      wait_evt(0, 1'b1, lat);
      chk("rel_lat", 32'(lat >= 6 && lat <= 7), 1);
      repeat (5) cyc();

      // 2 bounce
      nev = 0;
      for (int i = 0; i < 10; i++) begin
         KEY[0] = ~KEY[0];
         repeat (2) begin
            cyc();
            nev += int'(key_press[0]) + int'(key_release[0]);
         end
      end
      KEY[0] = 1'b1;
      repeat (10) begin
         cyc();
         nev += int'(key_press[0]) + int'(key_release[0]);
      end
      chk("bounce_evts", 32'(nev), 0);
      chk("bounce_lvl", 32'(key_level[0]), 0);

      // 3 hold-repeat
      KEY[1] = 1'b0;
      wait_evt(1, 1'b0, lat);
      chk("k1_press_lat", 32'(lat >= 6 && lat <= 7), 1);
      nrep = 0;
      bad  = 0;
      for (int off = 1; off <= 40; off++) begin
         cyc();
         if (key_repeat[1] === 1'b1) begin
            nrep++;
            if (off < HOLD || (off - HOLD) % REP != 0) bad++;
         end
      end
      chk("rep_count", 32'(nrep), 7);
      chk("rep_phase", 32'(bad), 0);
      KEY[1] = 1'b1;
      wait_evt(1, 1'b1, lat);
      chk("k1_rel_lat", 32'(lat >= 6 && lat <= 7), 1);
      nrep = 0;
      repeat (15) begin
         cyc();
         nrep += int'(key_repeat[1]);
      end
      chk("rep_after_rel", 32'(nrep), 0);

      // 4 release/repeat collision at P+15
      KEY[1] = 1'b0;
      wait_evt(1, 1'b0, lat);
      p = tb_cyc;
      repeat (9) cyc();
      KEY[1] = 1'b1;
      wait_evt(1, 1'b1, lat);
      chk("coll_cycle", 32'(tb_cyc - p), 15);
      chk("coll_norep", 32'(key_repeat[1]), 0);
      nrep = 0;
      repeat (15) begin
         cyc();
         nrep += int'(key_repeat[1]);
      end
      chk("coll_idle", 32'(nrep), 0);

      // 5 independence
      KEY[1] = 1'b0;
      wait_evt(1, 1'b0, lat);
      nrep = 0;
      bad  = 0;
      np   = 0;
      for (int off = 1; off <= 40; off++) begin
         cyc();
         if (off == 11) KEY[0] = 1'b0;
         if (key_repeat[1] === 1'b1) begin
            nrep++;
            if (off < HOLD || (off - HOLD) % REP != 0) bad++;
         end
         np += int'(key_press[0]);
      end
      chk("ind_rep_count", 32'(nrep), 7);
      chk("ind_rep_phase", 32'(bad), 0);
      chk("ind_k0_press", 32'(np), 1);
      KEY = '1;
      repeat (20) cyc();

      // 6 reset mid-hold
      KEY[0] = 1'b0;
      wait_evt(0, 1'b0, lat);
      repeat (12) cyc();
      chk("pre_rst_lvl", 32'(key_level[0]), 1);
      RESET_N = 1'b0;
      #1 chk_zero("midrst");
      repeat (3) cyc();
      RESET_N = 1'b1;
      np  = 0;
      lat = 99;
      for (int i = 1; i <= 15; i++) begin
         cyc();
         if (key_press[0] === 1'b1) begin
            np++;
            if (lat == 99) lat = i;
         end
      end
      chk("rst_press_cnt", 32'(np), 1);
      chk("rst_press_lat", 32'(lat >= 6 && lat <= 7), 1);
      KEY = '1;
      repeat (15) cyc();

      // random segments checked by the model every cycle
      for (int seg = 0; seg < 60; seg++) begin
         KEY = NK'($urandom);
         repeat ($urandom_range(1, 25)) cyc();
      end
      KEY = '1;
      repeat (30) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
